// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for register-to-register ALU
// instructions. It issues one instruction at a time and walks it through
// READ -> EXEC -> WB -> RESP. It owns a 32x32 register file in which r0
// always reads as zero.
module alu_op_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_ld,
    input  logic [1:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic [CNT_W-1:0] retired,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RESP} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    state_t            state_q, state_d;
    logic              ld_q;
    logic [1:0]        op_q;
    logic [4:0]        rd_q, rs1_q, rs2_q;
    logic [31:0]       imm_q, a_q, b_q, res_q, alu_d;
    logic [4:0]        out_rd_q;
    logic [31:0]       out_data_q;
    logic [CNT_W-1:0]  retired_q;
    logic [31:0]       regs_q [32];

    // Reads of r0 are forced to zero. Index 0 of the array is never written.
    function automatic logic [31:0] rf_read(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'd0 : regs_q[addr];
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign retired   = retired_q;
    assign dbg_data  = rf_read(dbg_addr);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. Backpressure can stall the FSM only in RESP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = RESP;
            RESP:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU. A shift amount of 32 or more clears the result, so the full B
    // is compared against 32, not just its low five bits.
    always_comb begin
        alu_d = 32'd0;
        unique case (op_q)
            OP_ADD: alu_d = a_q + b_q;
            OP_SUB: alu_d = a_q - b_q;
            OP_SHL: alu_d = (b_q >= 32'd32) ? 32'd0 : (a_q << b_q[4:0]);
            OP_SHR: alu_d = (b_q >= 32'd32) ? 32'd0 : (a_q >> b_q[4:0]);
            default: alu_d = 32'd0;
        endcase
        if (ld_q) alu_d = imm_q;
    end

    // Datapath: latch the instruction, fetch operands, execute, write back,
    // and count retired responses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ld_q       <= 1'b0;
            op_q       <= 2'd0;
            rd_q       <= 5'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            imm_q      <= 32'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            res_q      <= 32'd0;
            out_rd_q   <= 5'd0;
            out_data_q <= 32'd0;
            retired_q  <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    ld_q  <= in_ld;
                    op_q  <= in_op;
                    rd_q  <= in_rd;
                    rs1_q <= in_rs1;
                    rs2_q <= in_rs2;
                    imm_q <= in_imm;
                end
                READ: begin
                    a_q <= rf_read(rs1_q);
                    b_q <= rf_read(rs2_q);
                end
                EXEC: res_q <= alu_d;
                WB: begin
                    if (rd_q != 5'd0) regs_q[rd_q] <= res_q;
                    out_rd_q   <= rd_q;
                    out_data_q <= (rd_q == 5'd0) ? 32'd0 : res_q;
                end
                RESP: if (out_ready) retired_q <= retired_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
